// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/timing generator with clock divider,
// run/park control, strobes and a sync delay line. Optional frame
// counter port enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int CLK_DIV   = 1,
    parameter int PIPE_DLY  = 0,
    parameter int POS_W     = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    output logic             pix_en,
    output logic [POS_W-1:0] hpos,
    output logic [POS_W-1:0] vpos,
    output logic             hsync,
    output logic             vsync,
    output logic             display_on,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0]       frame_cnt
`endif
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // Reject nonsensical configurations at elaboration time
    generate
        if (H_DISPLAY < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
            V_DISPLAY < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1)
        begin : g_bad_field
            $error("vga_timing_gen: timing fields must be nonzero");
        end
        if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV out of range 1..16");
        end
        if (PIPE_DLY < 0 || PIPE_DLY > 8) begin : g_bad_dly
            $error("vga_timing_gen: PIPE_DLY out of range 0..8");
        end
        if (POS_W < 1 || POS_W > 16 ||
            (H_TOTAL - 1) >= (1 << POS_W) ||
            (V_TOTAL - 1) >= (1 << POS_W)) begin : g_bad_posw
            $error("vga_timing_gen: POS_W too narrow");
        end
    endgenerate

    localparam logic [POS_W-1:0] L_HLAST = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] L_VLAST = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0] L_HDISP = POS_W'(H_DISPLAY);
    localparam logic [POS_W-1:0] L_VDISP = POS_W'(V_DISPLAY);
    localparam logic [POS_W-1:0] L_HSS   = POS_W'(H_DISPLAY + H_FRONT);
    localparam logic [POS_W-1:0] L_HSE   = POS_W'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [POS_W-1:0] L_VSS   = POS_W'(V_DISPLAY + V_FRONT);
    localparam logic [POS_W-1:0] L_VSE   = POS_W'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [4:0]       L_DLAST = 5'(CLK_DIV - 1);
    localparam logic             L_HS_ON  = (HSYNC_POL != 0);
    localparam logic             L_VS_ON  = (VSYNC_POL != 0);
    // Inactive {hsync, vsync, display_on} levels
    localparam logic [2:0]       L_OFF    = {~L_HS_ON, ~L_VS_ON, 1'b0};

    logic [4:0]       r_div;
    logic [POS_W-1:0] r_hpos;
    logic [POS_W-1:0] r_vpos;
    logic             r_pix_en;
    logic             r_line_start;
    logic             r_frame_start;
    logic [2:0]       r_raw;

    logic             w_tick;
    logic             w_hwrap;
    logic [POS_W-1:0] w_hnext;
    logic [POS_W-1:0] w_vnext;
    logic             w_hs_act;
    logic             w_vs_act;
    logic             w_de;
    logic [2:0]       w_raw_next;
    logic [2:0]       w_out;

    // Next position and the sync levels that belong to it
    always_comb begin
        w_tick   = (r_div == L_DLAST);
        w_hwrap  = (r_hpos == L_HLAST);
        w_hnext  = w_hwrap ? '0 : r_hpos + POS_W'(1);
        w_vnext  = r_vpos;
        if (w_hwrap) begin
            w_vnext = (r_vpos == L_VLAST) ? '0 : r_vpos + POS_W'(1);
        end
        w_hs_act   = (w_hnext >= L_HSS) && (w_hnext < L_HSE);
        w_vs_act   = (w_vnext >= L_VSS) && (w_vnext < L_VSE);
        w_de       = (w_hnext < L_HDISP) && (w_vnext < L_VDISP);
        w_raw_next = {w_hs_act ? L_HS_ON : ~L_HS_ON,
                      w_vs_act ? L_VS_ON : ~L_VS_ON,
                      w_de};
    end

    // Divider, position counters, strobes and undelayed sync
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div         <= '0;
            r_hpos        <= L_HLAST;
            r_vpos        <= L_VLAST;
            r_pix_en      <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_raw         <= L_OFF;
        end else if (!run) begin
            r_div         <= '0;
            r_hpos        <= L_HLAST;
            r_vpos        <= L_VLAST;
            r_pix_en      <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_raw         <= L_OFF;
        end else begin
            r_pix_en      <= w_tick;
            r_line_start  <= w_tick && (w_hnext == '0);
            r_frame_start <= w_tick && (w_hnext == '0) && (w_vnext == '0);
            if (w_tick) begin
                r_div  <= '0;
                r_hpos <= w_hnext;
                r_vpos <= w_vnext;
                r_raw  <= w_raw_next;
            end else begin
                r_div  <= r_div + 5'd1;
            end
        end
    end

    generate
        if (PIPE_DLY == 0) begin : g_nodly
            assign w_out = r_raw;
        end else begin : g_dly
            logic [2:0] r_pipe [PIPE_DLY];
            // Tick-aligned delay line, flushed to idle levels on park
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < PIPE_DLY; i++) r_pipe[i] <= L_OFF;
                end else if (!run) begin
                    for (int i = 0; i < PIPE_DLY; i++) r_pipe[i] <= L_OFF;
                end else if (w_tick) begin
                    r_pipe[0] <= r_raw;
                    for (int i = 1; i < PIPE_DLY; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end
            assign w_out = r_pipe[PIPE_DLY-1];
        end
    endgenerate

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;
    // Counts frames; updates together with frame_start, holds when parked
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt <= '0;
        end else if (run && w_tick && w_hnext == '0 && w_vnext == '0) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end
    assign frame_cnt = r_frame_cnt;
`endif

    assign pix_en      = r_pix_en;
    assign hpos        = r_hpos;
    assign vpos        = r_vpos;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign hsync       = w_out[2];
    assign vsync       = w_out[1];
    assign display_on  = w_out[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: two small configurations (A: 7x6,
// undivided, no delay; B: 15x8, CLK_DIV=2, PIPE_DLY=2, active-high sync).
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset_n;
    logic run;

    logic       a_pe, a_hs, a_vs, a_de, a_ls, a_fs;
    logic [3:0] a_h, a_v;
    logic       b_pe, b_hs, b_vs, b_de, b_ls, b_fs;
    logic [3:0] b_h, b_v;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] a_fc, b_fc;
`endif

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .POS_W(4)
    ) u_a (
        .clk(clk), .reset_n(reset_n), .run(run),
        .pix_en(a_pe), .hpos(a_h), .vpos(a_v),
        .hsync(a_hs), .vsync(a_vs), .display_on(a_de),
        .line_start(a_ls), .frame_start(a_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(a_fc)
`endif
    );

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HSYNC_POL(1), .VSYNC_POL(1),
        .CLK_DIV(2), .PIPE_DLY(2), .POS_W(4)
    ) u_b (
        .clk(clk), .reset_n(reset_n), .run(run),
        .pix_en(b_pe), .hpos(b_h), .vpos(b_v),
        .hsync(b_hs), .vsync(b_vs), .display_on(b_de),
        .line_start(b_ls), .frame_start(b_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(b_fc)
`endif
    );

    typedef struct {
        logic run;
        int   h;
        int   v;
        logic hs;
        logic vs;
        logic de;
        logic ls;
        logic fs;
        logic pe;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hs_cnt;
        int fs_cnt;

        // run, hpos, vpos, hs, vs, de, ls, fs, pix_en  (instance A)
        tbl[0] = '{1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[1] = '{1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 3, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 4, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 5, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 6, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 0, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 6, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        reset_n = 1'b0;
        run     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst a_hpos", int'(a_h), 6);
        chk("rst a_vpos", int'(a_v), 5);
        chk("rst a_hsync", int'(a_hs), 1);
        chk("rst a_vsync", int'(a_vs), 1);
        chk("rst a_de", int'(a_de), 0);
        chk("rst a_pix_en", int'(a_pe), 0);
        chk("rst a_ls", int'(a_ls), 0);
        chk("rst a_fs", int'(a_fs), 0);
        chk("rst b_hpos", int'(b_h), 14);
        chk("rst b_vpos", int'(b_v), 7);
        chk("rst b_hsync", int'(b_hs), 0);
        chk("rst b_vsync", int'(b_vs), 0);
        chk("rst b_de", int'(b_de), 0);
`ifdef VGA_FRAME_CNT_EN
        chk("rst a_frame_cnt", int'(a_fc), 0);
`endif
        reset_n = 1'b1;
        step();

        // Table: A from park through first line, park, restart
        for (int i = 0; i < 10; i++) begin
            run = tbl[i].run;
            step();
            chk($sformatf("row%0d hpos", i), int'(a_h), tbl[i].h);
            chk($sformatf("row%0d vpos", i), int'(a_v), tbl[i].v);
            chk($sformatf("row%0d hsync", i), int'(a_hs), int'(tbl[i].hs));
            chk($sformatf("row%0d vsync", i), int'(a_vs), int'(tbl[i].vs));
            chk($sformatf("row%0d de", i), int'(a_de), int'(tbl[i].de));
            chk($sformatf("row%0d ls", i), int'(a_ls), int'(tbl[i].ls));
            chk($sformatf("row%0d fs", i), int'(a_fs), int'(tbl[i].fs));
            chk($sformatf("row%0d pix_en", i), int'(a_pe), int'(tbl[i].pe));
        end

        // A: vsync line, then simultaneous line+frame wrap
        repeat (28) step();
        chk("a vsync hpos", int'(a_h), 0);
        chk("a vsync vpos", int'(a_v), 4);
        chk("a vsync act", int'(a_vs), 0);
        chk("a vsync hs", int'(a_hs), 1);
        repeat (13) step();
        chk("a last hpos", int'(a_h), 6);
        chk("a last vpos", int'(a_v), 5);
        chk("a last vs", int'(a_vs), 1);
        chk("a last fs", int'(a_fs), 0);
        step();
        chk("a wrap hpos", int'(a_h), 0);
        chk("a wrap vpos", int'(a_v), 0);
        chk("a wrap ls", int'(a_ls), 1);
        chk("a wrap fs", int'(a_fs), 1);

        // B: divided clock with delay line and high sync polarity
        run = 1'b0;
        step();
        step();
        chk("b park hpos", int'(b_h), 14);
        chk("b park hs", int'(b_hs), 0);
        run = 1'b1;
        hs_cnt = 0;
        fs_cnt = 0;
        for (int k = 1; k <= 245; k++) begin
            step();
            if (k >= 2 && k <= 31 && b_hs) hs_cnt++;
            if (k >= 3 && k <= 241 && b_fs) fs_cnt++;
            if (k == 1) begin
                chk("b k1 pix_en", int'(b_pe), 0);
                chk("b k1 hpos", int'(b_h), 14);
            end
            if (k == 2) begin
                chk("b k2 hpos", int'(b_h), 0);
                chk("b k2 vpos", int'(b_v), 0);
                chk("b k2 pix_en", int'(b_pe), 1);
                chk("b k2 fs", int'(b_fs), 1);
                chk("b k2 ls", int'(b_ls), 1);
                chk("b k2 de", int'(b_de), 0);
            end
            if (k == 3) begin
                chk("b k3 hpos", int'(b_h), 0);
                chk("b k3 pix_en", int'(b_pe), 0);
                chk("b k3 fs", int'(b_fs), 0);
            end
            if (k == 5) chk("b k5 de", int'(b_de), 0);
            if (k == 6) chk("b k6 de", int'(b_de), 1);
            if (k == 25) chk("b k25 hs", int'(b_hs), 0);
            if (k == 26) begin
                chk("b k26 hpos", int'(b_h), 12);
                chk("b k26 hs", int'(b_hs), 1);
            end
            if (k == 31) chk("b hs clks/line", hs_cnt, 6);
            if (k == 32) begin
                chk("b k32 hpos", int'(b_h), 0);
                chk("b k32 vpos", int'(b_v), 1);
                chk("b k32 ls", int'(b_ls), 1);
                chk("b k32 hs", int'(b_hs), 0);
            end
            if (k == 155) chk("b k155 vs", int'(b_vs), 0);
            if (k == 156) begin
                chk("b k156 vpos", int'(b_v), 5);
                chk("b k156 vs", int'(b_vs), 1);
            end
            if (k == 241) chk("b fs inside frame", fs_cnt, 0);
            if (k == 242) begin
                chk("b k242 fs", int'(b_fs), 1);
                chk("b k242 hpos", int'(b_h), 0);
                chk("b k242 vpos", int'(b_v), 0);
            end
        end

        // Asynchronous reset mid-cycle
        step();
        chk("pre-rst a_hpos", int'(a_h), 0);
        chk("pre-rst b_de", int'(b_de), 1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst a_hpos", int'(a_h), 6);
        chk("arst a_vpos", int'(a_v), 5);
        chk("arst a_ls", int'(a_ls), 0);
        chk("arst a_pix_en", int'(a_pe), 0);
        chk("arst b_hpos", int'(b_h), 14);
        chk("arst b_de", int'(b_de), 0);
        chk("arst b_hs", int'(b_hs), 0);
`ifdef VGA_FRAME_CNT_EN
        chk("arst a_frame_cnt", int'(a_fc), 0);
        run = 1'b0;
        reset_n = 1'b1;
        step();
        run = 1'b1;
        for (int n = 1; n <= 1 + 42 * 255; n++) begin
            step();
            if (n == 1) chk("fc first", int'(a_fc), 1);
            if (n == 1 + 42 * 254) chk("fc 255", int'(a_fc), 255);
            if (n == 1 + 42 * 255) chk("fc wrap", int'(a_fc), 0);
        end
        run = 1'b0;
        step();
        step();
        chk("fc hold parked", int'(a_fc), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
